output_port_arbiter: RTL and testbench

Packet-level round-robin arbiter for one router output port. Up to `N_IN` input channels, each after its header parsing stage, request this port through their one-hot select bit. The arbiter grants one input at the start of packet (sop) and holds the grant until end of packet (eop). It forwards the winner's phits through one output register with ready/valid backpressure. It sits between the per-input header parsing units and the output link register of the synchronous router.

---
 rtl/noc_pkg.sv | 16 +
 rtl/output_port_arbiter_rr_picker.sv | 35 +++
 rtl/output_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_output_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared router definitions.
// Phit layout (PHIT_W bits): [34] vld, [33] sop, [32] eop, [31:0] payload.
// Also carries the output-port arbiter FSM state type.
package noc_pkg;

  localparam int PHIT_W   = 35;
  localparam int PHIT_VLD = 34;
  localparam int PHIT_SOP = 33;
  localparam int PHIT_EOP = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/output_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
// Ports:
//   cand   in  N      candidate vector
//   ptr    in  IDX_W  highest-priority index this cycle
//   found  out 1      at least one candidate present
//   winner out IDX_W  first candidate at or after ptr, wrapping modulo N
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  localparam int unsigned NU = N;

  int unsigned idx;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = (32'(ptr) + (NU - 1 - k)) % NU;
      if (cand[idx]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: packet-level round-robin arbiter for one router output.
// An input wins at sop and keeps the port until its eop; winner phits pass
// through one output register with ready/valid backpressure.
// Ports:
//   clk          in  1              rising-edge clock
//   reset        in  1              synchronous, active-low
//   req_i        in  N_IN           per-input select bit for this output
//   in_data      in  N_IN*PHIT_W    input phits, input i at [i*PHIT_W +: PHIT_W]
//   in_ready     out N_IN           phit of input i accepted when in_ready[i] & vld
//   out_ready    in  1              downstream can take a phit
//   out_req      out 1              vld of out_data (registered)
//   out_data     out PHIT_W         registered forwarded phit
//   grant        out N_IN           one-hot owner while locked, 0 when idle
//   err_timeout  out 1              one-cycle pulse on watchdog release
// Build option: define ARB_WATCHDOG_EN to release a stalled lock after
// TIMEOUT LOCKED cycles without an accepted phit; otherwise err_timeout is 0.
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int PHIT_W  = noc_pkg::PHIT_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN-1:0]          req_i,
  input  logic [N_IN*PHIT_W-1:0]   in_data,
  output logic [N_IN-1:0]          in_ready,
  input  logic                     out_ready,
  output logic                     out_req,
  output logic [PHIT_W-1:0]        out_data,
  output logic [N_IN-1:0]          grant,
  output logic                     err_timeout
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [N_IN-1:0] ONE = 1;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  arb_state_t        state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;

  logic [PHIT_W-1:0] phit [N_IN];
  logic [N_IN-1:0]   cand;
  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  sel;
  logic [PHIT_W-1:0] sel_phit;
  logic              acc;
  logic              wd_fire;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    if (32'(i) == N_IN - 1) return '0;
    return i + 1'b1;
  endfunction

  rr_picker #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_picker (
    .cand   (cand),
    .ptr    (rr_ptr),
    .found  (found),
    .winner (pick)
  );

  // Acceptance is gated by reset so nothing is consumed while in reset.
  always_comb begin
    in_ready = '0;
    acc      = 1'b0;
    sel      = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      phit[i] = in_data[i*PHIT_W +: PHIT_W];
      cand[i] = req_i[i] & phit[i][PHIT_VLD] & phit[i][PHIT_SOP];
    end
    if (reset && out_ready) begin
      if (state == ARB_LOCKED) begin
        in_ready[owner] = 1'b1;
        sel             = owner;
        acc             = phit[owner][PHIT_VLD];
      end else if (found) begin
        in_ready[pick] = 1'b1;
        sel            = pick;
        acc            = 1'b1;
      end
    end
    sel_phit = phit[sel];
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Fires on the TIMEOUT-th consecutive LOCKED cycle without an acceptance.
  assign wd_fire = (state == ARB_LOCKED) && out_ready && !acc &&
                   (32'(wd_cnt) == TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (!out_ready || acc || wd_fire || state != ARB_LOCKED) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign out_req = out_data[PHIT_VLD];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      out_data    <= '0;
      grant       <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wd_fire;
      if (out_ready) begin
        // Bubbles load as all-zero so out_req drops cleanly.
        out_data <= acc ? sel_phit : '0;
        if (state == ARB_IDLE) begin
          if (acc && !sel_phit[PHIT_EOP]) begin
            state <= ARB_LOCKED;
            owner <= sel;
            grant <= ONE << sel;
          end else if (acc) begin
            rr_ptr <= inc_idx(sel);
          end
        end else if ((acc && sel_phit[PHIT_EOP]) || wd_fire) begin
          state  <= ARB_IDLE;
          grant  <= '0;
          rr_ptr <= inc_idx(owner);
        end
      end
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;
  import noc_pkg::*;

  localparam int N = 4;
  localparam int W = PHIT_W;
`ifdef ARB_WATCHDOG_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_ready;
  logic             out_req;
  logic [W-1:0]     out_data;
  logic [N-1:0]     grant;
  logic             err_timeout;

  always #5 clk = ~clk;

  output_port_arbiter #(
    .N_IN    (N),
    .PHIT_W  (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_ready   (out_ready),
    .out_req     (out_req),
    .out_data    (out_data),
    .grant       (grant),
    .err_timeout (err_timeout)
  );

  logic [W-1:0] src [N][$];
  logic [W-1:0] sb [$];

  int n_checks = 0;
  int n_pass   = 0;

  // Snapshots of the cycle that the last tick() completed.
  logic [N-1:0] s_ir, s_gr;
  logic         s_oq, s_err;
  logic [W-1:0] s_od;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] mk(input bit s, input bit e, input logic [31:0] p);
    return {1'b1, s, e, p};
  endfunction

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src[i].size() != 0) begin
        in_data[i*W +: W] = src[i][0];
        req[i] = 1'b1;
      end else begin
        in_data[i*W +: W] = '0;
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] take;
    @(negedge clk);
    s_ir = in_ready; s_gr = grant; s_oq = out_req; s_od = out_data; s_err = err_timeout;
    if (reset && out_req && out_ready) begin
      if (sb.size() == 0) chk("sb_extra", 64'(out_data), 64'(0));
      else chk("sb_data", 64'(out_data), 64'(sb.pop_front()));
    end
    for (int i = 0; i < N; i++) take[i] = reset && in_ready[i] && in_data[i*W + PHIT_VLD];
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (take[i] && src[i].size() != 0) void'(src[i].pop_front());
    drive();
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 60 && (sb.size() != 0 || !srcs_empty()); c++) tick();
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [N-1:0] gexp [5];
    logic [N-1:0] irexp [4];
    int errs;

    // Reset with every input requesting.
    reset = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        src[i].push_back(mk(1, 1, 32'hA000 + 16*r + i));
        sb.push_back(mk(1, 1, 32'hA000 + 16*r + i));
      end
    drive();
    tick();
    repeat (3) begin
      tick();
      chk("rst_out_req", 64'(s_oq), 64'(0));
      chk("rst_grant", 64'(s_gr), 64'(0));
      chk("rst_in_ready", 64'(s_ir), 64'(0));
    end
    reset = 1'b1;
    tick();
    chk("first_win", 64'(s_ir), 64'(4'b0001));
    // Single-phit packets rotate 0,1,2,3,0,... with no output bubble.
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b2b_out_req", 64'(s_oq), 64'(1));
    end
    drain("rot_drain");

    // Input 2 sends a 4-phit packet.
    src[2].push_back(mk(1, 0, 32'hB0)); src[2].push_back(mk(0, 0, 32'hB1));
    src[2].push_back(mk(0, 0, 32'hB2)); src[2].push_back(mk(0, 1, 32'hB3));
    sb.push_back(mk(1, 0, 32'hB0)); sb.push_back(mk(0, 0, 32'hB1));
    sb.push_back(mk(0, 0, 32'hB2)); sb.push_back(mk(0, 1, 32'hB3));
    drive();
    gexp = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("pkt_grant", 64'(s_gr), 64'(gexp[k]));
    end
    drain("pkt_drain");

    // rr_ptr is now 3: input 3 beats input 0.
    src[0].push_back(mk(1, 1, 32'hC9)); src[3].push_back(mk(1, 1, 32'hD9));
    sb.push_back(mk(1, 1, 32'hD9)); sb.push_back(mk(1, 1, 32'hC9));
    drive();
    drain("ptr3_drain");

    // rr_ptr is now 1: input 1 wins, input 0 waits until input 1's eop.
    src[0].push_back(mk(1, 0, 32'hC0)); src[0].push_back(mk(0, 1, 32'hC1));
    src[1].push_back(mk(1, 0, 32'hD0)); src[1].push_back(mk(0, 0, 32'hD1));
    src[1].push_back(mk(0, 1, 32'hD2));
    sb.push_back(mk(1, 0, 32'hD0)); sb.push_back(mk(0, 0, 32'hD1));
    sb.push_back(mk(0, 1, 32'hD2)); sb.push_back(mk(1, 0, 32'hC0));
    sb.push_back(mk(0, 1, 32'hC1));
    drive();
    irexp = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("contend_in_ready", 64'(s_ir), 64'(irexp[k]));
    end
    drain("contend_drain");

    // Backpressure for 5 cycles mid-packet.
    src[3].push_back(mk(1, 0, 32'hE0)); src[3].push_back(mk(0, 0, 32'hE1));
    src[3].push_back(mk(0, 0, 32'hE2)); src[3].push_back(mk(0, 1, 32'hE3));
    sb.push_back(mk(1, 0, 32'hE0)); sb.push_back(mk(0, 0, 32'hE1));
    sb.push_back(mk(0, 0, 32'hE2)); sb.push_back(mk(0, 1, 32'hE3));
    drive();
    tick();
    tick();
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_in_ready", 64'(s_ir), 64'(0));
      chk("stall_hold", 64'(s_od), 64'(mk(0, 0, 32'hE1)));
    end
    out_ready = 1'b1;
    drain("stall_drain");

    // Owner goes silent after sop; another input is waiting.
    src[1].push_back(mk(1, 0, 32'hF0));
    sb.push_back(mk(1, 0, 32'hF0));
    drive();
    tick();
    tick();
    src[2].push_back(mk(1, 1, 32'hF2));
`ifdef ARB_WATCHDOG_EN
    sb.push_back(mk(1, 1, 32'hF2));
`endif
    drive();
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (s_err === 1'b1) errs++;
`ifndef ARB_WATCHDOG_EN
      chk("lock_grant", 64'(s_gr), 64'(4'b0010));
      chk("lock_in_ready", 64'(s_ir), 64'(4'b0010));
      chk("lock_no_err", 64'(s_err), 64'(0));
`endif
    end
`ifdef ARB_WATCHDOG_EN
    chk("wd_pulses", 64'(errs), 64'(1));
    drain("wd_drain");
`else
    chk("lock_err_count", 64'(errs), 64'(0));
    chk("lock_sb_empty", 64'(sb.size()), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
